// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable glitch-free clock divider producing a divided
// clock, a once-per-period tick strobe and the phase counter.
// Optional macro CLK_DIV_GEN_INV_OUT_EN adds a registered complement clk_out_n.
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   en        run request (level)
//   div_in    new divide ratio
//   div_load  strobe capturing div_in
//   div_ack   pulse when a pending ratio becomes active
//   clk_out   divided clock (registered)
//   clk_out_n complement of clk_out (macro only)
//   tick      pulse at the start of every period
//   cnt       phase counter 0..D-1
module clk_div_gen #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
`ifdef CLK_DIV_GEN_INV_OUT_EN
  output logic             clk_out_n,
`endif
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam logic [WIDTH-1:0] L_DEF = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] L_TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend;
  logic             r_pv;
  logic [WIDTH-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;
  logic             r_ack;

  state_e           w_state_nxt;
  logic             w_wrap;
  logic             w_apply;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_seq;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;
  logic [WIDTH-1:0] w_div_in_c;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_pend_nxt;
  logic             w_pv_nxt;
  logic             w_ack_nxt;

  assign w_wrap     = (r_cnt == r_div - L_ONE);
  // ceil(D/2) without needing an extra bit
  assign w_half     = (r_div >> 1) + {{(WIDTH-1){1'b0}}, r_div[0]};
  assign w_cnt_seq  = w_wrap ? '0 : r_cnt + L_ONE;
  assign w_div_in_c = (div_in < L_TWO) ? L_TWO : div_in;
  // ratio may only change where a period begins (or while stopped)
  assign w_apply    = (r_state == S_IDLE) || w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= L_DEF;
      r_pend  <= '0;
      r_pv    <= 1'b0;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_pend  <= w_pend_nxt;
      r_pv    <= w_pv_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clk   <= w_clk_nxt;
      r_tick  <= w_tick_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)
          w_state_nxt = S_RUN;
        else if (w_wrap)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt  = w_cnt_seq;
    w_clk_nxt  = (w_cnt_seq < w_half);
    w_tick_nxt = (w_cnt_seq == '0);
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_clk_nxt  = en;
        w_tick_nxt = en;
      end
      S_RUN: ;
      S_DRAIN: begin
        if (w_wrap && !en) begin
          w_cnt_nxt  = '0;
          w_clk_nxt  = 1'b0;
          w_tick_nxt = 1'b0;
        end
      end
      default: begin
        w_cnt_nxt  = '0;
        w_clk_nxt  = 1'b0;
        w_tick_nxt = 1'b0;
      end
    endcase
  end

  // a load on the apply edge bypasses the pending register
  always_comb begin
    w_div_nxt  = r_div;
    w_pend_nxt = r_pend;
    w_pv_nxt   = r_pv;
    w_ack_nxt  = 1'b0;
    if (w_apply && div_load) begin
      w_div_nxt = w_div_in_c;
      w_pv_nxt  = 1'b0;
      w_ack_nxt = 1'b1;
    end else if (w_apply && r_pv) begin
      w_div_nxt = r_pend;
      w_pv_nxt  = 1'b0;
      w_ack_nxt = 1'b1;
    end else if (div_load) begin
      w_pend_nxt = w_div_in_c;
      w_pv_nxt   = 1'b1;
    end
  end

`ifdef CLK_DIV_GEN_INV_OUT_EN
  logic r_clk_n;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_clk_n <= 1'b1;
    else
      r_clk_n <= ~w_clk_nxt;
  end

  assign clk_out_n = r_clk_n;
`endif

  assign cnt     = r_cnt;
  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign div_ack = r_ack;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed self-checking bench for clk_div_gen.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_clk_div_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic       clk_out;
  logic       tick;
  logic [7:0] cnt;
`ifdef CLK_DIV_GEN_INV_OUT_EN
  logic       clk_out_n;
`endif

  int total = 0;
  int bad   = 0;

  clk_div_gen #(.WIDTH(8), .DEF_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .clk_out  (clk_out),
    .tick     (tick),
`ifdef CLK_DIV_GEN_INV_OUT_EN
    .clk_out_n(clk_out_n),
`endif
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({clk_out, tick, div_ack} !== 3'b000) begin
      bad++;
      $display("FAIL reset_out got %b want 000", {clk_out, tick, div_ack});
    end
    total++;
    if (cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt got %0d want 0", cnt);
    end
`ifdef CLK_DIV_GEN_INV_OUT_EN
    total++;
    if (clk_out_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_clkn got %b want 1", clk_out_n);
    end
`endif
    step();
    total++;
    if ({clk_out, tick, cnt} !== 10'd0) begin
      bad++;
      $display("FAIL idle_hold got %b/%b/%0d want 0/0/0", clk_out, tick, cnt);
    end
  endtask

  task automatic test_div2();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (clk_out !== (i % 2 == 0) || tick !== (i % 2 == 0)
          || cnt !== 8'(i % 2)) begin
        bad++;
        $display("FAIL div2 cyc%0d got clk=%b tick=%b cnt=%0d want %0d/%0d/%0d",
                 i, clk_out, tick, cnt, i % 2 == 0, i % 2 == 0, i % 2);
      end
    end
  endtask

  task automatic test_div5();
    int c;
    do_reset();
    div_in   = 8'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if (div_ack !== 1'b1 || clk_out !== 1'b0) begin
      bad++;
      $display("FAIL div5_idle_ack got ack=%b clk=%b want 1/0", div_ack, clk_out);
    end
    step();
    total++;
    if (div_ack !== 1'b0) begin
      bad++;
      $display("FAIL div5_ack_once got %b want 0", div_ack);
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      c = i % 5;
      total++;
      if (cnt !== 8'(c) || clk_out !== (c < 3) || tick !== (c == 0)) begin
        bad++;
        $display("FAIL div5 cyc%0d got cnt=%0d clk=%b tick=%b want %0d/%0d/%0d",
                 i, cnt, clk_out, tick, c, c < 3, c == 0);
      end
`ifdef CLK_DIV_GEN_INV_OUT_EN
      total++;
      if (clk_out_n !== ~clk_out) begin
        bad++;
        $display("FAIL div5_clkn cyc%0d got %b want %b", i, clk_out_n, ~clk_out);
      end
`endif
    end
  endtask

  task automatic test_ratio_change();
    int c;
    do_reset();
    div_in   = 8'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    step();
    step();
    total++;
    if (cnt !== 8'd1) begin
      bad++;
      $display("FAIL chg_pre got cnt=%0d want 1", cnt);
    end
    div_in   = 8'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if (cnt !== 8'd2 || clk_out !== 1'b0 || div_ack !== 1'b0) begin
      bad++;
      $display("FAIL chg_c2 got cnt=%0d clk=%b ack=%b want 2/0/0",
               cnt, clk_out, div_ack);
    end
    step();
    total++;
    if (cnt !== 8'd3 || div_ack !== 1'b0) begin
      bad++;
      $display("FAIL chg_c3 got cnt=%0d ack=%b want 3/0", cnt, div_ack);
    end
    step();
    total++;
    if (cnt !== 8'd0 || div_ack !== 1'b1 || tick !== 1'b1 || clk_out !== 1'b1) begin
      bad++;
      $display("FAIL chg_wrap got cnt=%0d ack=%b tick=%b clk=%b want 0/1/1/1",
               cnt, div_ack, tick, clk_out);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      c = i % 7;
      total++;
      if (cnt !== 8'(c) || clk_out !== (c < 4) || tick !== (c == 0)
          || div_ack !== 1'b0) begin
        bad++;
        $display("FAIL chg_d7 cyc%0d got cnt=%0d clk=%b tick=%b ack=%b want %0d/%0d/%0d/0",
                 i, cnt, clk_out, tick, div_ack, c, c < 4, c == 0);
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    div_in   = 8'd5;
    div_load = 1'b1;
    step();
    div_in = 8'd0;
    step();
    total++;
    if (div_ack !== 1'b1) begin
      bad++;
      $display("FAIL clamp_ack0 got %b want 1", div_ack);
    end
    div_in = 8'd1;
    step();
    div_load = 1'b0;
    total++;
    if (div_ack !== 1'b1) begin
      bad++;
      $display("FAIL clamp_ack1 got %b want 1", div_ack);
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (cnt !== 8'(i % 2) || clk_out !== (i % 2 == 0)) begin
        bad++;
        $display("FAIL clamp_run cyc%0d got cnt=%0d clk=%b want %0d/%0d",
                 i, cnt, clk_out, i % 2, i % 2 == 0);
      end
    end
  endtask

  task automatic test_double_load();
    int c;
    do_reset();
    div_in   = 8'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    step();
    div_in   = 8'd6;
    div_load = 1'b1;
    step();
    div_in = 8'd9;
    step();
    div_load = 1'b0;
    total++;
    if (cnt !== 8'd2 || div_ack !== 1'b0) begin
      bad++;
      $display("FAIL dbl_mid got cnt=%0d ack=%b want 2/0", cnt, div_ack);
    end
    step();
    step();
    total++;
    if (cnt !== 8'd0 || div_ack !== 1'b1 || tick !== 1'b1) begin
      bad++;
      $display("FAIL dbl_wrap got cnt=%0d ack=%b tick=%b want 0/1/1",
               cnt, div_ack, tick);
    end
    for (int i = 1; i <= 9; i++) begin
      step();
      c = i % 9;
      total++;
      if (cnt !== 8'(c) || clk_out !== (c < 5) || div_ack !== 1'b0) begin
        bad++;
        $display("FAIL dbl_d9 cyc%0d got cnt=%0d clk=%b ack=%b want %0d/%0d/0",
                 i, cnt, clk_out, div_ack, c, c < 5);
      end
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp_cnt [6];
    logic [5:0] exp_clk;
    int         c;
    exp_cnt = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0};
    exp_clk = 6'b000001;
    do_reset();
    div_in   = 8'd6;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (cnt !== exp_cnt[i] || clk_out !== exp_clk[i] || tick !== 1'b0) begin
        bad++;
        $display("FAIL drain cyc%0d got cnt=%0d clk=%b tick=%b want %0d/%b/0",
                 i, cnt, clk_out, tick, exp_cnt[i], exp_clk[i]);
      end
`ifdef CLK_DIV_GEN_INV_OUT_EN
      total++;
      if (clk_out_n !== ~clk_out) begin
        bad++;
        $display("FAIL drain_clkn cyc%0d got %b want %b", i, clk_out_n, ~clk_out);
      end
`endif
    end
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    step();
    total++;
    if (cnt !== 8'd3) begin
      bad++;
      $display("FAIL rearm_pre got cnt=%0d want 3", cnt);
    end
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      c = (4 + i) % 6;
      total++;
      if (cnt !== 8'(c) || clk_out !== (c < 3) || tick !== (c == 0)) begin
        bad++;
        $display("FAIL rearm cyc%0d got cnt=%0d clk=%b tick=%b want %0d/%0d/%0d",
                 i, cnt, clk_out, tick, c, c < 3, c == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    div_in   = 8'd8;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    step();
    div_in   = 8'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    step();
    total++;
    if (cnt !== 8'd3 || clk_out !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got cnt=%0d clk=%b want 3/1", cnt, clk_out);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    en    = 1'b0;
    total++;
    if ({clk_out, tick, div_ack} !== 3'b000 || cnt !== 8'd0) begin
      bad++;
      $display("FAIL rstmid_vals got clk=%b tick=%b ack=%b cnt=%0d want 0/0/0/0",
               clk_out, tick, div_ack, cnt);
    end
`ifdef CLK_DIV_GEN_INV_OUT_EN
    total++;
    if (clk_out_n !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_clkn got %b want 1", clk_out_n);
    end
`endif
    step();
    total++;
    if (div_ack !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_noack got %b want 0", div_ack);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (cnt !== 8'(i % 2) || clk_out !== (i % 2 == 0) || div_ack !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_d2 cyc%0d got cnt=%0d clk=%b ack=%b want %0d/%0d/0",
                 i, cnt, clk_out, div_ack, i % 2, i % 2 == 0);
      end
    end
  endtask

  task automatic test_load_with_start();
    int c;
    do_reset();
    en       = 1'b1;
    div_in   = 8'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    total++;
    if ({tick, div_ack, clk_out} !== 3'b111 || cnt !== 8'd0) begin
      bad++;
      $display("FAIL simul_start got tick=%b ack=%b clk=%b cnt=%0d want 1/1/1/0",
               tick, div_ack, clk_out, cnt);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      c = i % 3;
      total++;
      if (cnt !== 8'(c) || clk_out !== (c < 2) || tick !== (c == 0)) begin
        bad++;
        $display("FAIL simul_d3 cyc%0d got cnt=%0d clk=%b tick=%b want %0d/%0d/%0d",
                 i, cnt, clk_out, tick, c, c < 2, c == 0);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    test_reset();
    test_div2();
    test_div5();
    test_ratio_change();
    test_clamp();
    test_double_load();
    test_drain();
    test_reset_mid();
    test_load_with_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Programmable, glitch-free clock divider. It consumes the free-running system clock from the clock source and inverter stage and produces a divided clock-enable waveform `clk_out`, a once-per-period `tick` strobe, and the phase counter. Downstream logic uses these as a slow timebase. The divide ratio is changed only on a period boundary, and stopping only happens at the end of a period, so no runt pulses ever appear on `clk_out`.

## Interface
- `WIDTH`, 8: width of the divide ratio and of the phase counter.
- `DEF_DIV`, 2: divide ratio loaded at reset. Must be ≥ 2.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: run request. Level-sensitive.
- `div_in` in WIDTH: new divide ratio.
- `div_load` in 1: one-cycle strobe that captures `div_in` into the pending register.
- `div_ack` out 1: one-cycle pulse when a pending ratio becomes active.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse at the start of every period.
- `cnt` out WIDTH: phase counter, range 0..D−1.

## Operation
- Active ratio D. Any loaded value below 2 is clamped to 2.
- High time H = ceil(D/2).
- Registered state:
  - `state` ∈ {IDLE, RUN, DRAIN}
  - D
  - pending ratio P, with flag `pv`
- IDLE:
  - `cnt`=0, `clk_out`=0, `tick`=0.
  - `en`=1 → RUN. On that edge: `cnt`←0, `clk_out`←1, `tick`←1.
- RUN, every edge:
  - `cnt` ← (`cnt`==D−1) ? 0 : `cnt`+1.
  - `clk_out` ← (next `cnt` < H).
  - `tick` ← (next `cnt`==0).
  - `en`=0 sampled → DRAIN.
- DRAIN:
  - Counts exactly as RUN.
  - On the wrap edge (`cnt`==D−1): go to IDLE, `cnt`←0, `clk_out`←0, `tick`←0.
  - `en`=1 sampled in DRAIN → RUN with no break in the waveform.
- Ratio loading:
  - `div_load`=1 sets P←clamp(`div_in`), `pv`←1.
  - A second load before application overwrites P. Only one `div_ack` is issued.
- Ratio application:
  - In IDLE: applied on the next edge, `div_ack`=1 for one cycle.
  - In RUN/DRAIN: applied on the wrap edge. The new D governs the period starting at `cnt`=0. `div_ack` is coincident with `tick`.
  - `div_load` on the wrap edge itself bypasses P and applies the value at that same edge.
- Simultaneous `div_load` and `en` rise in IDLE: the new ratio applies to the first period, and `div_ack` and `tick` pulse together.

## Timing
- Reset values:
  - `clk_out`=0, `tick`=0, `div_ack`=0, `cnt`=0
  - `state`=IDLE, D=`DEF_DIV`, `pv`=0
- Reset mid-operation: all of the above take effect on the next edge. Any pending ratio is discarded and no ack is issued.
- Start latency: 1 cycle from `en` sampled high to `clk_out`=1.
- Period is exactly D `clk` cycles: H high, D−H low.
- Stop latency: `clk_out` falls no earlier than the end of the current period. The last high phase is never shortened.
- `cnt` wraps from D−1 to 0. It never reaches D and never exceeds 2^WIDTH−1.

## Configuration
- Macro: `CLK_DIV_GEN_INV_OUT_EN`.
- When defined:
  - Adds output `clk_out_n` (out 1), a separately registered complement of `clk_out`.
  - Reset value of `clk_out_n` is 1 in IDLE and after reset.
  - It is never equal to `clk_out` on any cycle.
- When undefined: the port and its register are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then `en`=1 with D=2 → `clk_out` 1,0,1,0… from the cycle after `en`; `tick` on every other cycle; `cnt` toggles 0/1.
- D=5 running:
  - `clk_out` high 3 cycles, low 2.
  - `tick` every 5 cycles.
  - `cnt` 0..4 then 0.
- Ratio change:
  - D=4 running, `div_load` with 7 at `cnt`=1 → period continues at 4.
  - At the wrap, `div_ack`=`tick`=1, and the next period is 7 cycles, high 4.
- Clamping:
  - `div_load` with 0, then with 1, in IDLE → `div_ack` after each; running gives D=2.
  - Two loads (6 then 9) in one period → one `div_ack`, D=9.
- Drain:
  - D=6, `en`=0 at `cnt`=1 → remaining cycles completed, then IDLE with `clk_out`=0.
  - `en` re-raised at `cnt`=3 → seamless continuation.
- Reset mid-run:
  - `rst_n`=0 at `cnt`=3 with D=8 and a pending load → next edge all reset values, D=2, no `div_ack`.
  - With `CLK_DIV_GEN_INV_OUT_EN` defined → `clk_out_n` is the complement of `clk_out` in every scenario above.
